// File: rtl/bp_sacc_io_arbiter.sv
// Shares one LCE I/O link among engines: combinational round-robin command grant with lock-until-yumi;
// responses return in order via an ID FIFO and a one-entry buffer (1-cycle latency, refill on same-cycle yumi).
module bp_sacc_io_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_ready_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_yumi_i
);

  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);
  localparam logic [lg_req_lp:0]   num_req_w_lp = (lg_req_lp+1)'(num_req_p);
  localparam logic [num_req_p-1:0] one_hot_lp   = {{(num_req_p-1){1'b0}}, 1'b1};

  logic [lg_req_lp-1:0]   rr_q, rr_d, lock_id_q, lock_id_d, cand_id;
  logic [lg_req_lp-1:0]   buf_id_q, buf_id_d;
  logic                   lock_v_q, lock_v_d, buf_v_q, buf_v_d, cand_found;
  logic [msg_width_p-1:0] buf_data_q, buf_data_d;
  logic [lg_req_lp-1:0]   fifo_mem_q [max_outstanding_p];
  logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic [lg_req_lp:0]     scan_sum;
  logic                   fifo_full, fifo_empty, cmd_fire, resp_fire;

  // A locked grant wins; otherwise scan upward from rr_q with wraparound.
  always_comb begin
    cand_found = lock_v_q;
    cand_id    = lock_id_q;
    scan_sum   = '0;
    if (!lock_v_q) begin
      for (int k = 0; k < num_req_p; k++) begin
        scan_sum = {1'b0, rr_q} + (lg_req_lp+1)'(k);
        if (scan_sum >= num_req_w_lp) scan_sum = scan_sum - num_req_w_lp;
        if (!cand_found && req_cmd_v_i[scan_sum[lg_req_lp-1:0]]) begin
          cand_found = 1'b1;
          cand_id    = scan_sum[lg_req_lp-1:0];
        end
      end
    end
  end

  assign fifo_full  = (cnt_q == cnt_w_lp'(max_outstanding_p));
  assign fifo_empty = (cnt_q == '0);

  assign io_cmd_v_o     = !reset_i && cand_found && !fifo_full;
  assign io_cmd_o       = req_cmd_i[cand_id*msg_width_p +: msg_width_p];
  assign cmd_fire       = io_cmd_v_o && io_cmd_yumi_i;
  assign req_cmd_yumi_o = cmd_fire ? (one_hot_lp << cand_id) : '0;

  // Ready never looks at io_resp_v_i, only at state and the engine-side yumi.
  assign io_resp_ready_o = !reset_i && !fifo_empty && (!buf_v_q || req_resp_yumi_i[buf_id_q]);
  assign resp_fire       = io_resp_v_i && io_resp_ready_o;
  assign req_resp_v_o    = (!reset_i && buf_v_q) ? (one_hot_lp << buf_id_q) : '0;
  assign req_resp_o      = buf_data_q;

  always_comb begin
    rr_d       = rr_q;
    lock_v_d   = lock_v_q;
    lock_id_d  = lock_id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    buf_v_d    = buf_v_q;
    buf_id_d   = buf_id_q;
    buf_data_d = buf_data_q;

    if (cmd_fire) begin
      rr_d     = (cand_id == lg_req_lp'(num_req_p-1)) ? '0 : cand_id + 1'b1;
      lock_v_d = 1'b0;
      wr_ptr_d = (wr_ptr_q == ptr_w_lp'(max_outstanding_p-1)) ? '0 : wr_ptr_q + 1'b1;
    end else if (io_cmd_v_o) begin
      lock_v_d  = 1'b1;
      lock_id_d = cand_id;
    end

    if (resp_fire) begin
      rd_ptr_d   = (rd_ptr_q == ptr_w_lp'(max_outstanding_p-1)) ? '0 : rd_ptr_q + 1'b1;
      buf_v_d    = 1'b1;
      buf_id_d   = fifo_mem_q[rd_ptr_q];
      buf_data_d = io_resp_i;
    end else if (buf_v_q && req_resp_yumi_i[buf_id_q]) begin
      buf_v_d = 1'b0;
    end

    case ({cmd_fire, resp_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q      <= '0;
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      buf_v_q   <= 1'b0;
      buf_id_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      buf_v_q   <= buf_v_d;
      buf_id_q  <= buf_id_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_data_q <= buf_data_d;
    if (cmd_fire) fifo_mem_q[wr_ptr_q] <= cand_id;
  end

`ifndef SYNTHESIS
  logic resp_v_empty_q;
  always_ff @(posedge clk_i) resp_v_empty_q <= !reset_i && io_resp_v_i && fifo_empty;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io_resp_v_i && fifo_empty && resp_v_empty_q))
        else $error("io_resp_v_i held high with no outstanding command");
      assert ((req_resp_yumi_i & ~req_resp_v_o) == '0)
        else $error("req_resp_yumi_i on a non-destination engine");
    end
  end
`endif

endmodule

// File: tb/tb_bp_sacc_io_arbiter.sv
// Directed bench for bp_sacc_io_arbiter: inputs change on the falling edge, outputs are
// compared 1ns later, state advances on the rising edge.
module tb_bp_sacc_io_arbiter;
  localparam int N = 2;
  localparam int W = 16;
  localparam int D = 4;
  localparam logic [W-1:0] CMD0 = 16'hA000, CMD1 = 16'hB111;
  localparam logic [W-1:0] RSP_A = 16'h1A1A, RSP_B = 16'h2B2B, RSP_C = 16'h3C3C;

  logic clk = 1'b0;
  logic reset_i;
  logic [N*W-1:0] req_cmd_i;
  logic [N-1:0] req_cmd_v_i, req_cmd_yumi_o, req_resp_v_o, req_resp_yumi_i;
  logic [W-1:0] io_cmd_o, io_resp_i, req_resp_o;
  logic io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_sacc_io_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(D)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i)
  );

  task automatic quiet_inputs();
    req_cmd_v_i = '0; io_cmd_yumi_i = 1'b0; io_resp_v_i = 1'b0;
    io_resp_i = '0; req_resp_yumi_i = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_i = 1'b1;
    quiet_inputs();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_i = 1'b1;
    req_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1; req_resp_yumi_i = '0;
    @(negedge clk); #1;
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_v: got %b expected 0", io_cmd_v_o); end
    checks++; if (req_cmd_yumi_o !== 2'b00) begin errors++; $display("FAIL rst_cmd_yumi: got %b expected 00", req_cmd_yumi_o); end
    checks++; if (io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL rst_resp_ready: got %b expected 0", io_resp_ready_o); end
    checks++; if (req_resp_v_o !== 2'b00) begin errors++; $display("FAIL rst_resp_v: got %b expected 00", req_resp_v_o); end
    @(negedge clk);
    reset_i = 1'b0;
    quiet_inputs();
  endtask

  task automatic test_fairness();
    logic [5:0] exp_v;
    logic [1:0] exp_y [6];
    logic [W-1:0] exp_d [6];
    exp_v = 6'b001111;
    exp_y = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_d = '{CMD0, CMD1, CMD0, CMD1, CMD0, CMD0};
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      req_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1;
      #1;
      checks++; if (io_cmd_v_o !== exp_v[c]) begin errors++; $display("FAIL fair_cmd_v[%0d]: got %b expected %b", c, io_cmd_v_o, exp_v[c]); end
      checks++; if (req_cmd_yumi_o !== exp_y[c]) begin errors++; $display("FAIL fair_yumi[%0d]: got %b expected %b", c, req_cmd_yumi_o, exp_y[c]); end
      if (exp_v[c]) begin
        checks++; if (io_cmd_o !== exp_d[c]) begin errors++; $display("FAIL fair_cmd_data[%0d]: got %h expected %h", c, io_cmd_o, exp_d[c]); end
      end
      @(negedge clk);
    end
    // FIFO full: a same-cycle pop must not open a slot.
    io_resp_v_i = 1'b1; io_resp_i = RSP_A;
    #1;
    checks++; if (io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL fair_pop_ready: got %b expected 1", io_resp_ready_o); end
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL fair_full_pop_v: got %b expected 0", io_cmd_v_o); end
    @(negedge clk);
    io_resp_v_i = 1'b0;
    #1;
    checks++; if (req_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL fair_after_pop_yumi: got %b expected 01", req_cmd_yumi_o); end
    checks++; if (req_resp_v_o !== 2'b01) begin errors++; $display("FAIL fair_resp_dest: got %b expected 01", req_resp_v_o); end
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic test_lock();
    reset_dut();
    req_cmd_v_i = 2'b10; io_cmd_yumi_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (io_cmd_o !== CMD1 || io_cmd_v_o !== 1'b1) begin errors++; $display("FAIL lock_hold[%0d]: got v=%b %h expected v=1 %h", c, io_cmd_v_o, io_cmd_o, CMD1); end
      checks++; if (req_cmd_yumi_o !== 2'b00) begin errors++; $display("FAIL lock_no_yumi[%0d]: got %b expected 00", c, req_cmd_yumi_o); end
      @(negedge clk);
      req_cmd_v_i = 2'b11;
    end
    io_cmd_yumi_i = 1'b1;
    #1;
    checks++; if (req_cmd_yumi_o !== 2'b10 || io_cmd_o !== CMD1) begin errors++; $display("FAIL lock_release: got yumi=%b %h expected yumi=10 %h", req_cmd_yumi_o, io_cmd_o, CMD1); end
    @(negedge clk);
    req_cmd_v_i = 2'b01;
    #1;
    checks++; if (req_cmd_yumi_o !== 2'b01 || io_cmd_o !== CMD0) begin errors++; $display("FAIL lock_next_grant: got yumi=%b %h expected yumi=01 %h", req_cmd_yumi_o, io_cmd_o, CMD0); end
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic test_ordering();
    logic [1:0] issue [3];
    logic [1:0] exp_rv [5];
    logic [W-1:0] rsp [3];
    logic [W-1:0] exp_rd [5];
    logic [4:0] exp_rdy;
    issue  = '{2'b10, 2'b01, 2'b10};
    rsp    = '{RSP_A, RSP_B, RSP_C};
    exp_rv = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    exp_rd = '{RSP_A, RSP_A, RSP_B, RSP_C, RSP_C};
    exp_rdy = 5'b00111;
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      req_cmd_v_i = issue[c]; io_cmd_yumi_i = 1'b1;
      #1;
      checks++; if (req_cmd_yumi_o !== issue[c]) begin errors++; $display("FAIL ord_issue[%0d]: got %b expected %b", c, req_cmd_yumi_o, issue[c]); end
      @(negedge clk);
    end
    req_cmd_v_i = '0; io_cmd_yumi_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      io_resp_v_i = (c < 3);
      io_resp_i = (c < 3) ? rsp[c] : '0;
      req_resp_yumi_i = exp_rv[c];
      #1;
      checks++; if (req_resp_v_o !== exp_rv[c]) begin errors++; $display("FAIL ord_resp_v[%0d]: got %b expected %b", c, req_resp_v_o, exp_rv[c]); end
      if (exp_rv[c] != 2'b00) begin
        checks++; if (req_resp_o !== exp_rd[c]) begin errors++; $display("FAIL ord_resp_data[%0d]: got %h expected %h", c, req_resp_o, exp_rd[c]); end
      end
      checks++; if (io_resp_ready_o !== exp_rdy[c]) begin errors++; $display("FAIL ord_ready[%0d]: got %b expected %b", c, io_resp_ready_o, exp_rdy[c]); end
      @(negedge clk);
    end
    quiet_inputs();
  endtask

  task automatic test_back_pressure();
    reset_dut();
    req_cmd_v_i = 2'b01; io_cmd_yumi_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (req_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL bp_issue[%0d]: got %b expected 01", c, req_cmd_yumi_o); end
      @(negedge clk);
    end
    req_cmd_v_i = '0; io_cmd_yumi_i = 1'b0;
    io_resp_v_i = 1'b1; io_resp_i = RSP_A;
    @(negedge clk);
    io_resp_i = RSP_B;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", c, io_resp_ready_o); end
      checks++; if (req_resp_v_o !== 2'b01 || req_resp_o !== RSP_A) begin errors++; $display("FAIL bp_stall_hold[%0d]: got %b %h expected 01 %h", c, req_resp_v_o, req_resp_o, RSP_A); end
      @(negedge clk);
    end
    req_resp_yumi_i = 2'b01;
    #1;
    checks++; if (io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", io_resp_ready_o); end
    @(negedge clk);
    io_resp_v_i = 1'b0;
    #1;
    checks++; if (req_resp_v_o !== 2'b01 || req_resp_o !== RSP_B) begin errors++; $display("FAIL bp_refill: got %b %h expected 01 %h", req_resp_v_o, req_resp_o, RSP_B); end
    @(negedge clk);
    req_resp_yumi_i = '0;
    #1;
    checks++; if (req_resp_v_o !== 2'b00) begin errors++; $display("FAIL bp_drain: got %b expected 00", req_resp_v_o); end
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic test_empty_fifo();
    reset_dut();
    io_resp_v_i = 1'b1; io_resp_i = RSP_C;
    #1;
    checks++; if (io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL empty_ready: got %b expected 0", io_resp_ready_o); end
    @(negedge clk);
    io_resp_v_i = 1'b0;
    #1;
    checks++; if (req_resp_v_o !== 2'b00) begin errors++; $display("FAIL empty_not_accepted: got %b expected 00", req_resp_v_o); end
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic test_mid_reset();
    reset_dut();
    req_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1;
    repeat (3) @(negedge clk);
    // Push and pop together: three IDs stay outstanding and rr_q lands on engine 1.
    req_cmd_v_i = 2'b01; io_resp_v_i = 1'b1; io_resp_i = RSP_A;
    #1;
    checks++; if (req_cmd_yumi_o !== 2'b01 || io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL mr_push_pop: got yumi=%b rdy=%b expected yumi=01 rdy=1", req_cmd_yumi_o, io_resp_ready_o); end
    @(negedge clk);
    quiet_inputs();
    #1;
    checks++; if (req_resp_v_o !== 2'b01) begin errors++; $display("FAIL mr_buf_valid: got %b expected 01", req_resp_v_o); end
    @(negedge clk);
    reset_i = 1'b1;
    req_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1;
    #1;
    checks++; if (io_cmd_v_o !== 1'b0 || req_cmd_yumi_o !== 2'b00 || req_resp_v_o !== 2'b00 || io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL mr_during_reset: got v=%b y=%b rv=%b rdy=%b expected all 0", io_cmd_v_o, req_cmd_yumi_o, req_resp_v_o, io_resp_ready_o); end
    @(negedge clk);
    reset_i = 1'b0;
    quiet_inputs();
    #1;
    checks++; if (io_cmd_v_o !== 1'b0 || req_cmd_yumi_o !== 2'b00 || req_resp_v_o !== 2'b00 || io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL mr_after_reset: got v=%b y=%b rv=%b rdy=%b expected all 0", io_cmd_v_o, req_cmd_yumi_o, req_resp_v_o, io_resp_ready_o); end
    @(negedge clk);
    req_cmd_v_i = 2'b11;
    #1;
    checks++; if (io_cmd_v_o !== 1'b1 || io_cmd_o !== CMD0) begin errors++; $display("FAIL mr_rr_zero: got v=%b %h expected v=1 %h", io_cmd_v_o, io_cmd_o, CMD0); end
    checks++; if (io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL mr_fifo_empty: got %b expected 0", io_resp_ready_o); end
    @(negedge clk);
    quiet_inputs();
  endtask

  initial begin
    reset_i = 1'b1;
    req_cmd_i = {CMD1, CMD0};
    quiet_inputs();
    test_reset();
    test_fairness();
    test_lock();
    test_ordering();
    test_back_pressure();
    test_empty_fifo();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
